// File: rtl/axi4_lite_lstm_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : axi4_lite_lstm_master
// Brief  : Single-outstanding AXI4-Lite initiator behind a cmd/rsp handshake,
//          with a saturating count of non-OKAY responses.
// Rev    : 1.0  initial release
// ============================================================================
module axi4_lite_lstm_master #(
    parameter logic [2:0] PROT      = 3'b000,
    parameter int         ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    // command / response side
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic [ERR_WIDTH-1:0] err_count,
    // AXI4-Lite master side
    output logic [31:0]          awaddr,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    output logic [31:0]          araddr,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    localparam logic [ERR_WIDTH-1:0] c_err_max = '1;
    localparam logic [ERR_WIDTH-1:0] c_err_one = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_wstrb;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_arvalid;
    logic                   r_bready;
    logic                   r_rready;
    logic                   r_rsp_valid;
    logic [31:0]            r_rsp_rdata;
    logic [1:0]             r_rsp_resp;
    logic [ERR_WIDTH-1:0]   r_err_count;

    logic                   w_aw_pend;
    logic                   w_w_pend;
    logic                   w_cap_valid;
    logic [1:0]             w_cap_resp;

    // Each write channel stays pending until its own handshake completes.
    assign w_aw_pend   = r_awvalid & ~awready;
    assign w_w_pend    = r_wvalid  & ~wready;

    assign w_cap_valid = ((r_state == ST_WR_RESP) & bvalid & r_bready) |
                         ((r_state == ST_RD_DATA) & rvalid & r_rready);
    assign w_cap_resp  = (r_state == ST_WR_RESP) ? bresp : rresp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_err_count <= '0;
        end else begin
            if (w_cap_valid && (w_cap_resp != 2'b00) && (r_err_count != c_err_max))
                r_err_count <= r_err_count + c_err_one;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    r_awvalid <= w_aw_pend;
                    r_wvalid  <= w_w_pend;
                    if (!w_aw_pend && !w_w_pend) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= bresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= rdata;
                        r_rsp_resp  <= rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign err_count = r_err_count;

    assign awaddr    = r_addr;
    assign awprot    = PROT;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign araddr    = r_addr;
    assign arprot    = PROT;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_lstm_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_axi4_lite_lstm_master
// Brief  : Scoreboard bench with a latency-configurable AXI4-Lite slave model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi4_lite_lstm_master;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT signals
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] err_count;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    axi4_lite_lstm_master #(.PROT(3'b000), .ERR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .err_count(err_count),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // narrow-counter instance used to reach saturation quickly
    logic        cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2;
    logic [31:0] rsp_rdata2, awaddr2, wdata2, araddr2, rdata2;
    logic [1:0]  rsp_resp2, err_count2, bresp2, rresp2;
    logic [2:0]  awprot2, arprot2;
    logic [3:0]  wstrb2;
    logic        awvalid2, awready2, wvalid2, wready2, bvalid2, bready2;
    logic        arvalid2, arready2, rvalid2, rready2;

    axi4_lite_lstm_master #(.PROT(3'b000), .ERR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(1'b0),
        .cmd_addr(32'h0000_0040), .cmd_wdata(32'h0), .cmd_wstrb(4'h0),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
        .rsp_resp(rsp_resp2), .err_count(err_count2),
        .awaddr(awaddr2), .awprot(awprot2), .awvalid(awvalid2), .awready(awready2),
        .wdata(wdata2), .wstrb(wstrb2), .wvalid(wvalid2), .wready(wready2),
        .bresp(bresp2), .bvalid(bvalid2), .bready(bready2),
        .araddr(araddr2), .arprot(arprot2), .arvalid(arvalid2), .arready(arready2),
        .rdata(rdata2), .rresp(rresp2), .rvalid(rvalid2), .rready(rready2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // slave configuration and per-transaction observations
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0]  slv_resp = 2'b00;
    logic [31:0] slv_rdata = 32'h0;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;
    int          aw_cyc, w_cyc, ar_cyc, rready_cyc, early_rdy, pay_bad;

    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_seen, w_seen, ar_seen, b_fire, r_fire;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_fire = 0; r_fire = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0; rdata = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0; b_fire = 0; r_fire = 0;
            end else begin
                // write response: only after both AW and W handshakes have happened
                if (b_fire) begin
                    bvalid = 0; b_fire = 0; aw_seen = 0; w_seen = 0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if ((bready || rready) && (awvalid || wvalid || arvalid)) early_rdy++;
                if (aw_seen && w_seen && !bvalid) begin
                    if (b_cnt >= b_lat) begin bvalid = 1; bresp = slv_resp; end
                    else b_cnt++;
                end
                b_fire = bvalid && bready;

                if (awvalid) begin
                    aw_cyc++;
                    if (awaddr !== exp_addr || awprot !== 3'b000) pay_bad++;
                end
                if (awvalid && !aw_seen && aw_cnt >= aw_lat) begin awready = 1; aw_seen = 1; end
                else begin awready = 0; if (awvalid && !aw_seen) aw_cnt++; end

                if (wvalid) begin
                    w_cyc++;
                    if (wdata !== exp_wdata || wstrb !== exp_wstrb) pay_bad++;
                end
                if (wvalid && !w_seen && w_cnt >= w_lat) begin wready = 1; w_seen = 1; end
                else begin wready = 0; if (wvalid && !w_seen) w_cnt++; end

                // read channels
                if (r_fire) begin
                    rvalid = 0; rdata = 0; r_fire = 0; ar_seen = 0; ar_cnt = 0; r_cnt = 0;
                end
                if (rready) rready_cyc++;
                if (ar_seen && !rvalid) begin
                    if (r_cnt >= r_lat) begin rvalid = 1; rdata = slv_rdata; rresp = slv_resp; end
                    else r_cnt++;
                end
                r_fire = rvalid && rready;

                if (arvalid) begin
                    ar_cyc++;
                    if (araddr !== exp_addr || arprot !== 3'b000) pay_bad++;
                end
                if (arvalid && !ar_seen && ar_cnt >= ar_lat) begin arready = 1; ar_seen = 1; end
                else begin arready = 0; if (arvalid && !ar_seen) ar_cnt++; end
            end
        end
    end

    // always-SLVERR read slave for the narrow instance
    initial begin
        awready2 = 0; wready2 = 0; bvalid2 = 0; bresp2 = 0;
        arready2 = 1; rvalid2 = 0; rresp2 = 2'b10; rdata2 = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) rvalid2 = 0;
            else if (rvalid2 && !rready2) rvalid2 = 0;
            else if (rready2 && !rvalid2) rvalid2 = 1;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] model_err = 16'h0;

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input int hold, output int lat);
        exp_t e;
        int   n;
        int   acc;
        exp_addr = addr; exp_wdata = wd; exp_wstrb = strb;
        e.rdata = wr ? 32'h0 : slv_rdata;
        e.resp  = slv_resp;
        sb.push_back(e);
        if (slv_resp != 2'b00 && model_err != 16'hFFFF) model_err = model_err + 16'h1;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; rready_cyc = 0; early_rdy = 0; pay_bad = 0;

        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check_eq("cmd_accept_timeout", 32'h0, 32'h1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check_eq("rsp_valid_timeout", 32'h0, 32'h1);
        lat = cyc - acc;

        if (sb.size() == 0) check_eq("scoreboard_empty", 32'h0, 32'h1);
        else begin
            e = sb.pop_front();
            check_eq("rsp_rdata", rsp_rdata, e.rdata);
            check_eq("rsp_resp", {30'h0, rsp_resp}, {30'h0, e.resp});
        end
        check_eq("err_count", {16'h0, err_count}, {16'h0, model_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check_eq("hold_rsp_rdata", rsp_rdata, e.rdata);
            check_eq("hold_rsp_resp", {30'h0, rsp_resp}, {30'h0, e.resp});
            check_eq("hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check_eq("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
        check_eq("cmd_ready_return", {31'h0, cmd_ready}, 32'h1);
    endtask

    task automatic rd2(input logic [1:0] exp_cnt);
        int n;
        cmd_valid2 = 1;
        n = 0;
        while (!cmd_ready2 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check_eq("dut2_accept_timeout", 32'h0, 32'h1);
        @(negedge clk);
        cmd_valid2 = 0;
        n = 0;
        while (!rsp_valid2 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check_eq("dut2_rsp_timeout", 32'h0, 32'h1);
        check_eq("dut2_resp", {30'h0, rsp_resp2}, 32'h2);
        check_eq("dut2_err_count", {30'h0, err_count2}, {30'h0, exp_cnt});
        rsp_ready2 = 1;
        @(negedge clk);
        rsp_ready2 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        logic [1:0]  sat_exp;
        rst = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        cmd_valid2 = 0; rsp_ready2 = 0;
        repeat (3) @(negedge clk);

        check_eq("rst_awvalid", {31'h0, awvalid}, 32'h0);
        check_eq("rst_wvalid", {31'h0, wvalid}, 32'h0);
        check_eq("rst_arvalid", {31'h0, arvalid}, 32'h0);
        check_eq("rst_bready", {31'h0, bready}, 32'h0);
        check_eq("rst_rready", {31'h0, rready}, 32'h0);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_err_count", {16'h0, err_count}, 32'h0);
        check_eq("rst_awaddr", awaddr, 32'h0);
        check_eq("rst_wdata", wdata, 32'h0);
        rst = 1;
        @(negedge clk);
        check_eq("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // zero-wait write
        do_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, lat);
        check_eq("wr0_latency", lat, 32'd3);
        check_eq("wr0_aw_cycles", aw_cyc, 32'd1);
        check_eq("wr0_w_cycles", w_cyc, 32'd1);
        check_eq("wr0_payload", pay_bad, 32'd0);

        // AW delayed 3 cycles, W immediate
        aw_lat = 3;
        do_cmd(1'b1, 32'h0000_0010, 32'hCAFE_0001, 4'h3, 0, lat);
        aw_lat = 0;
        check_eq("wr1_latency", lat, 32'd6);
        check_eq("wr1_aw_cycles", aw_cyc, 32'd4);
        check_eq("wr1_w_cycles", w_cyc, 32'd1);
        check_eq("wr1_early_bready", early_rdy, 32'd0);
        check_eq("wr1_payload", pay_bad, 32'd0);

        // read with rvalid delayed 5 cycles
        r_lat = 5; slv_rdata = 32'h1234_5678;
        do_cmd(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, lat);
        r_lat = 0;
        check_eq("rd0_latency", lat, 32'd8);
        check_eq("rd0_ar_cycles", ar_cyc, 32'd1);
        check_eq("rd0_rready_cycles", rready_cyc, 32'd6);
        check_eq("rd0_early_rready", early_rdy, 32'd0);
        check_eq("rd0_payload", pay_bad, 32'd0);

        // three SLVERR responses with a slow consumer
        slv_resp = 2'b10;
        for (int i = 0; i < 3; i++) begin
            slv_rdata = 32'hA5A5_0000 + i;
            do_cmd(i != 1, 32'h0000_0100 + 4 * i, 32'h1111_1111 * (i + 1), 4'hF, 4, lat);
        end
        slv_resp = 2'b00;
        check_eq("slverr_err_count", {16'h0, err_count}, 32'd3);

        // reset while waiting for the write response
        b_lat = 10;
        exp_addr = 32'h0000_0200; exp_wdata = 32'h5555_AAAA; exp_wstrb = 4'hF;
        cmd_valid = 1; cmd_write = 1; cmd_addr = exp_addr; cmd_wdata = exp_wdata; cmd_wstrb = 4'hF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 0;
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check_eq("wr_resp_wait_timeout", 32'h0, 32'h1);
        #2 rst = 0;
        #1;
        model_err = 16'h0;
        check_eq("arst_awvalid", {31'h0, awvalid}, 32'h0);
        check_eq("arst_wvalid", {31'h0, wvalid}, 32'h0);
        check_eq("arst_bready", {31'h0, bready}, 32'h0);
        check_eq("arst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("arst_err_count", {16'h0, err_count}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        b_lat = 0;
        @(negedge clk);
        check_eq("arst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        slv_rdata = 32'h0BAD_F00D;
        do_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, lat);
        check_eq("arst_rd_latency", lat, 32'd3);

        // saturation on a 2-bit counter: bring it to max-1, then two more errors
        sat_exp = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sat_exp != 2'b11) sat_exp = sat_exp + 2'd1;
            rd2(sat_exp);
        end
        check_eq("sat_final", {30'h0, err_count2}, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
